// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: two requester ports, hold, scoreboard
// query/issue lines and the registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int N = 32
);
  logic         a_valid;
  logic [4:0]   a_rd;
  logic [N-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [4:0]   b_rd;
  logic [N-1:0] b_data;
  logic         b_ready;
  logic         wb_hold;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         busy_rs1;
  logic         busy_rs2;
  logic         regWrite;
  logic [4:0]   wr_rd;
  logic [N-1:0] wr_data;

  modport master (
    output a_valid, a_rd, a_data,
    input  a_ready,
    output b_valid, b_rd, b_data,
    input  b_ready,
    output wb_hold, issue_valid, issue_rd,
    output rs1, rs2,
    input  busy_rs1, busy_rs2,
    input  regWrite, wr_rd, wr_data
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    output a_ready,
    input  b_valid, b_rd, b_data,
    output b_ready,
    input  wb_hold, issue_valid, issue_rd,
    input  rs1, rs2,
    output busy_rs1, busy_rs2,
    output regWrite, wr_rd, wr_data
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// port A (ALU) and port B (multi-cycle/load). Ports: clk, rst (async,
// active-high), bus (wb_port_arbiter_if.slave): a_*/b_* valid/rd/data
// with combinational ready, wb_hold, registered regWrite/wr_rd/wr_data.
// Optional RAW scoreboard (issue_*, rs1/rs2 -> busy_rs1/busy_rs2) is
// built only when WB_SCOREBOARD_EN is defined; otherwise busy_* = 0.
module wb_port_arbiter #(
  parameter int N = 32
) (
  input logic            clk,
  input logic            rst,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } rr_t;

  rr_t          rr, rr_d;
  logic         gnt_a, gnt_b, acc;
  logic [4:0]   acc_rd;
  logic [N-1:0] acc_data;
  logic         acc_we;

  logic         we_q;
  logic [4:0]   rd_q;
  logic [N-1:0] data_q;

  // Ready is forced low during reset; hold blocks every grant.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && !bus.wb_hold) begin
      if (bus.a_valid && (!bus.b_valid || rr == PRI_A))
        gnt_a = 1'b1;
      else if (bus.b_valid)
        gnt_b = 1'b1;
    end
  end

  always_comb begin
    acc      = gnt_a | gnt_b;
    acc_rd   = gnt_b ? bus.b_rd : bus.a_rd;
    acc_data = gnt_b ? bus.b_data : bus.a_data;
    // Writes to x0 are consumed but never reach the register file.
    acc_we   = acc && (acc_rd != 5'd0);
  end

  always_comb begin
    rr_d = rr;
    unique case (1'b1)
      gnt_a:   rr_d = PRI_B;
      gnt_b:   rr_d = PRI_A;
      default: rr_d = rr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr <= PRI_A;
    else     rr <= rr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= 5'd0;
      data_q <= '0;
    end else begin
      we_q <= acc_we;
      if (acc_we) begin
        rd_q   <= acc_rd;
        data_q <= acc_data;
      end
    end
  end

  assign bus.a_ready  = gnt_a;
  assign bus.b_ready  = gnt_b;
  assign bus.regWrite = we_q;
  assign bus.wr_rd    = rd_q;
  assign bus.wr_data  = data_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy, busy_d;

  // Clear on accept, then set on issue: a same-rd issue is newer.
  always_comb begin
    busy_d = busy;
    if (acc)
      busy_d[acc_rd] = 1'b0;
    if (bus.issue_valid)
      busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  // The regWrite term covers the cycle before the write lands.
  assign bus.busy_rs1 = busy[bus.rs1] |
    (we_q && rd_q == bus.rs1 && bus.rs1 != 5'd0);
  assign bus.busy_rs2 = busy[bus.rs2] |
    (we_q && rd_q == bus.rs2 && bus.rs2 != 5'd0);
`else
  logic unused_sb;
  assign unused_sb = ^{bus.issue_valid, bus.issue_rd,
                       bus.rs1, bus.rs2};
  assign bus.busy_rs1 = 1'b0;
  assign bus.busy_rs2 = 1'b0;
`endif

endmodule
